qc_syndrome_check: RTL and testbench
====================================

Name: qc_syndrome_check

Overview:
- Decoder-side counterpart of the QC-LDPC encoder's circulant shift table.
- Receives a codeword read back from NAND as a serial bit stream and accumulates its 512-bit parity-check syndrome.
- Each data block contributes through a weight-3 circulant whose three shift values it fetches from the shift table. The parity block contributes through the identity circulant.
- After the last bit it scans the syndrome and reports zero/non-zero and its Hamming weight to the read-path ECC controller.

Parameters:
- Z, 512: circulant size (bits per block).
- SW, 9: shift-field width (log2 Z).
- NB, 16: number of data blocks. The parity block is index NB.
- WW, 10: syndrome-weight output width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  block accepts a bit this cycle.
- in_bit  in  1  codeword bit. Order: block 0 bit 0 first, bit index then block index ascending.
- in_first  in  1  marks the first bit of a codeword.
- blk_idx  out  5  current block index (0..NB), to the shift table.
- shift_in  in  3*SW  {s2,s1,s0} for block blk_idx. Fields are [26:18], [17:9], [8:0].
- busy  out  1  high in ACCUM or SCAN.
- syn_valid  out  1  one-cycle result strobe.
- syn_zero  out  1  syndrome is all zero; valid with syn_valid, held until next result.
- syn_weight  out  WW  number of ones in the syndrome; held like syn_zero.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; syndrome, bit_cnt, blk_idx, syn_weight all 0; syn_valid 0; syn_zero 0; busy 0.
  - in_ready returns to 1 on the first clock edge after reset release.
- Handshake: a bit is accepted when in_valid && in_ready.
  - in_ready=1 in IDLE and ACCUM, 0 in SCAN and DONE.
- Shift-table timing: shift_in is consumed combinationally in the same cycle as the accepted bit. The table must present the entry for the current blk_idx in that cycle; a registered static table satisfies this.
- IDLE:
  - Accepted bit with in_first=1: clear syndrome, apply this bit as position (blk 0, bit 0), set bit_cnt=1, go ACCUM.
  - Accepted bit with in_first=0: dropped.
- ACCUM, accepted bit at (blk b, bit j) with in_bit=1:
  - b < NB: syndrome ^= onehot((j+s0) mod Z) ^ onehot((j+s1) mod Z) ^ onehot((j+s2) mod Z).
  - Modular add is the SW-bit sum truncated. Equal shifts cancel by XOR.
  - b = NB: syndrome ^= onehot(j).
  - in_bit=0 leaves the syndrome unchanged.
- Counters: bit_cnt wraps Z-1 -> 0 and increments blk_idx.
  - After bit (NB, Z-1) is accepted, go SCAN. Total bits per codeword = (NB+1)*Z = 8704.
- Restart: in_first=1 on an accepted bit in ACCUM aborts the current codeword and restarts exactly as from IDLE. No result is issued for the aborted codeword.
- SCAN:
  - Runs exactly Z cycles, counting syndrome ones: one bit per cycle via a scan pointer or shifting the syndrome register.
  - Weight is saturated at 2^WW-1. This cannot be reached with Z=512.
- DONE: one cycle.
  - syn_valid=1; syn_weight/syn_zero updated in that cycle; then IDLE.
- Latency: last bit accepted at edge T -> syn_valid high in the cycle after edge T+Z+1. That is 513 cycles after the last bit.
- Outputs:
  - blk_idx holds its value in IDLE (0) and across in_valid gaps.
  - in_valid gaps inside ACCUM are allowed and change nothing.
- Asynchronous reset mid-ACCUM or mid-SCAN: immediate return to reset values; no syn_valid.

Test Plan:
- All-zero 8704-bit codeword, shift_in={176,1,499} for all blocks -> syn_valid once, 513 cycles after last bit; syn_zero=1, syn_weight=0.
- Only block 0 bit 0 =1, shifts {176,1,499} -> syndrome bits 1, 176, 499 set; syn_weight=3, syn_zero=0.
- Only block 3 bit 511 =1, shift_in={363,19,5} -> wrap-around positions 4, 18, 362; syn_weight=3.
- Only block 5 bit 10 =1, shift_in={5,5,7} -> duplicate shifts cancel; only bit 17 set; syn_weight=1.
- Only parity block bit 100 =1 -> syn_weight=1. Same plus block 0 bit 0 with shifts {0,0,100} also =1 -> syn_zero=1.
- Robustness:
  - Start a codeword, reassert in_first at bit 3000, then send a full all-zero codeword -> one syn_valid, syn_zero=1.
  - Pulse rst_n low during SCAN -> no syn_valid; outputs at reset values.

Source files
------------

// File: rtl/qc_syndrome_check_if.sv
// Stream, shift-table and result signals of the QC-LDPC syndrome checker.
// The master drives codeword bits and shift-table entries; the slave is the checker.
interface qc_syndrome_check_if #(
  parameter int SW = 9,
  parameter int WW = 10
);
  logic            in_valid;
  logic            in_ready;
  logic            in_bit;
  logic            in_first;
  logic [4:0]      blk_idx;
  logic [3*SW-1:0] shift_in;
  logic            busy;
  logic            syn_valid;
  logic            syn_zero;
  logic [WW-1:0]   syn_weight;

  modport master (
    output in_valid, in_bit, in_first, shift_in,
    input  in_ready, blk_idx, busy, syn_valid, syn_zero, syn_weight
  );

  modport slave (
    input  in_valid, in_bit, in_first, shift_in,
    output in_ready, blk_idx, busy, syn_valid, syn_zero, syn_weight
  );
endinterface

// File: rtl/qc_syndrome_check.sv
// Accumulates the parity-check syndrome of a serially received QC-LDPC codeword,
// then scans it bit by bit to report zero/non-zero and its Hamming weight.
module qc_syndrome_check #(
  parameter int Z  = 512,
  parameter int SW = 9,
  parameter int NB = 16,
  parameter int WW = 10
) (
  input logic               clk,
  input logic               rst_n,
  qc_syndrome_check_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  state_t        r_state, w_next;
  logic [Z-1:0]  r_syn;
  logic [SW-1:0] r_bit_cnt;   // bit index in ACCUM, scan pointer in SCAN
  logic [4:0]    r_blk_idx;
  logic [WW-1:0] r_weight;
  logic [WW-1:0] r_syn_weight;
  logic          r_syn_zero;
  logic          r_syn_valid;
  logic          r_in_ready;

  logic          w_accept;
  logic          w_restart;
  logic          w_parity;
  logic          w_wrap;
  logic          w_last_bit;
  logic [SW-1:0] w_pos;
  logic [SW-1:0] w_p0, w_p1, w_p2;
  logic [Z-1:0]  w_mask;

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_restart  = w_accept && bus.in_first;
  assign w_pos      = w_restart ? '0 : r_bit_cnt;
  assign w_parity   = !w_restart && (r_blk_idx == 5'(NB));
  assign w_wrap     = (r_bit_cnt == SW'(Z - 1));
  assign w_last_bit = w_wrap && (r_blk_idx == 5'(NB));

  // Sums are SW bits wide, so the modulo-Z wrap is plain truncation.
  assign w_p0 = w_pos + bus.shift_in[SW-1:0];
  assign w_p1 = w_pos + bus.shift_in[2*SW-1:SW];
  assign w_p2 = w_pos + bus.shift_in[3*SW-1:2*SW];

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_mask = '0;
    if (w_parity) begin
      w_mask[w_pos] = 1'b1;
    end else begin
      w_mask[w_p0] = ~w_mask[w_p0];
      w_mask[w_p1] = ~w_mask[w_p1];
      w_mask[w_p2] = ~w_mask[w_p2];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_restart) w_next = ACCUM;
      ACCUM:   if (w_accept && !bus.in_first && w_last_bit) w_next = SCAN;
      SCAN:    if (w_wrap) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: the syndrome register is reset too, since a cleared syndrome is part of the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn        <= '0;
      r_bit_cnt    <= '0;
      r_blk_idx    <= '0;
      r_weight     <= '0;
      r_syn_weight <= '0;
      r_syn_zero   <= 1'b0;
      r_syn_valid  <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE) || (w_next == ACCUM);
      r_syn_valid <= (r_state == DONE);
      case (r_state)
        IDLE, ACCUM: begin
          if (w_restart) begin
            r_syn     <= bus.in_bit ? w_mask : '0;
            r_bit_cnt <= SW'(1);
            r_blk_idx <= '0;
          end else if (w_accept && (r_state == ACCUM)) begin
            if (bus.in_bit) r_syn <= r_syn ^ w_mask;
            if (w_wrap) begin
              r_bit_cnt <= '0;
              if (w_last_bit) begin
                r_blk_idx <= '0;
                r_weight  <= '0;
              end else begin
                r_blk_idx <= r_blk_idx + 5'd1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + SW'(1);
            end
          end
        end
        SCAN: begin
          r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + SW'(1);
          if (r_syn[r_bit_cnt] && (r_weight != '1)) r_weight <= r_weight + WW'(1);
        end
        DONE: begin
          r_syn_weight <= r_weight;
          r_syn_zero   <= (r_weight == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.blk_idx    = r_blk_idx;
  assign bus.busy       = (r_state == ACCUM) || (r_state == SCAN);
  assign bus.syn_valid  = r_syn_valid;
  assign bus.syn_zero   = r_syn_zero;
  assign bus.syn_weight = r_syn_weight;

endmodule

// File: tb/tb_qc_syndrome_check.sv
// Scoreboard bench for qc_syndrome_check: expected results are queued as each
// codeword is sent and compared when syn_valid strobes.
module tb_qc_syndrome_check;
  localparam int Z     = 512;
  localparam int SW    = 9;
  localparam int NB    = 16;
  localparam int WW    = 10;
  localparam int NBITS = (NB + 1) * Z;

  typedef struct packed {
    logic          zero;
    logic [WW-1:0] weight;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qc_syndrome_check_if #(.SW(SW), .WW(WW)) bus ();

  qc_syndrome_check #(.Z(Z), .SW(SW), .NB(NB), .WW(WW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [3*SW-1:0] tbl [0:NB];
  assign bus.shift_in = tbl[bus.blk_idx];

  bit   cw [0:NBITS-1];
  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   last_acc  = 0;
  int   n_results = 0;
  bit   gaps      = 1'b0;
  logic prev_v    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: compares each strobe against the oldest queued expectation.
  always @(negedge clk) begin
    if (prev_v) begin
      n_checks++;
      if (bus.syn_valid !== 1'b0) $display("FAIL syn_valid_width got=%b exp=0", bus.syn_valid);
      else n_pass++;
    end
    prev_v = (bus.syn_valid === 1'b1);
    if (bus.syn_valid === 1'b1) begin
      exp_t e;
      n_results++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_result got syn_valid=1 exp no result");
      end else begin
        n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (bus.syn_zero !== e.zero) $display("FAIL syn_zero got=%b exp=%b", bus.syn_zero, e.zero);
        else n_pass++;
        n_checks++;
        if (bus.syn_weight !== e.weight) $display("FAIL syn_weight got=%0d exp=%0d", bus.syn_weight, e.weight);
        else n_pass++;
        n_checks++;
        if (cyc - last_acc !== Z + 1) $display("FAIL latency got=%0d exp=%0d", cyc - last_acc, Z + 1);
        else n_pass++;
      end
    end
  end

  function automatic logic [3*SW-1:0] sh(input int s2, input int s1, input int s0);
    logic [SW-1:0] a, b, c;
    a = SW'(s2); b = SW'(s1); c = SW'(s0);
    return {a, b, c};
  endfunction

  task automatic set_shifts(input int s2, input int s1, input int s0);
    for (int b = 0; b <= NB; b++) tbl[b] = sh(s2, s1, s0);
  endtask

  task automatic clear_cw();
    for (int i = 0; i < NBITS; i++) cw[i] = 1'b0;
  endtask

  // Sends cw[0..n-1], in_first on the first bit; optional random in_valid gaps.
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      int   tries = 0;
      bit   done  = 1'b0;
      logic v, rdy;
      while (!done) begin
        @(negedge clk);
        bus.in_valid = gaps ? ($urandom_range(15) != 0) : 1'b1;
        bus.in_bit   = cw[i];
        bus.in_first = (i == 0);
        v   = bus.in_valid;
        rdy = bus.in_ready;
        @(posedge clk);
        #1;
        if (v && rdy) begin
          done     = 1'b1;
          last_acc = cyc;
        end else if (++tries > 64) begin
          n_checks++;
          $display("FAIL send_stall got in_ready=0 at bit %0d exp in_ready=1", i);
          @(negedge clk);
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int start = n_results;
    for (int k = 0; k < Z + 64 && n_results == start; k++) @(posedge clk);
    repeat (4) @(negedge clk);
    n_checks++;
    if (n_results == start) $display("FAIL %s_timeout got no syn_valid exp one", name);
    else n_pass++;
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.blk_idx} !== {1'b1, 1'b0, 5'd0})
      $display("FAIL %s_idle got ready=%b busy=%b blk=%0d exp 1 0 0", name, bus.in_ready, bus.busy, bus.blk_idx);
    else n_pass++;
  endtask

  task automatic run_case(input string name, input logic zero, input int weight);
    exp_t e;
    e.zero   = zero;
    e.weight = WW'(weight);
    sb.push_back(e);
    send(NBITS);
    wait_result(name);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_first = 1'b0;
    set_shifts(176, 1, 499);
    clear_cw();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.syn_valid, bus.syn_zero, bus.syn_weight, bus.blk_idx} !== '0)
      $display("FAIL reset_values got ready=%b busy=%b v=%b z=%b w=%0d blk=%0d exp all 0",
               bus.in_ready, bus.busy, bus.syn_valid, bus.syn_zero, bus.syn_weight, bus.blk_idx);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_all_zero();
    set_shifts(176, 1, 499);
    clear_cw();
    run_case("all_zero", 1'b1, 0);
  endtask

  task automatic test_single_data();
    set_shifts(176, 1, 499);
    clear_cw(); cw[0] = 1'b1;
    run_case("blk0_bit0", 1'b0, 3);
    set_shifts(363, 19, 5);
    clear_cw(); cw[3*Z + 511] = 1'b1;
    run_case("blk3_wrap", 1'b0, 3);
    set_shifts(5, 5, 7);
    clear_cw(); cw[5*Z + 10] = 1'b1;
    run_case("dup_shift", 1'b0, 1);
  endtask

  task automatic test_parity();
    set_shifts(176, 1, 499);
    clear_cw(); cw[NB*Z + 100] = 1'b1;
    gaps = 1'b1;
    run_case("parity", 1'b0, 1);
    gaps = 1'b0;
    set_shifts(0, 0, 100);
    cw[0] = 1'b1;
    run_case("cancel", 1'b1, 0);
  endtask

  task automatic test_restart();
    exp_t e;
    set_shifts(176, 1, 499);
    clear_cw(); cw[5] = 1'b1; cw[2000] = 1'b1;
    send(3000);
    clear_cw();
    e.zero = 1'b1; e.weight = '0;
    sb.push_back(e);
    send(NBITS);
    wait_result("restart");
  endtask

  task automatic test_reset_in_scan();
    int start;
    set_shifts(176, 1, 499);
    clear_cw(); cw[0] = 1'b1;
    send(NBITS);
    repeat (100) @(posedge clk);
    #2;
    n_checks++;
    if ({bus.busy, bus.in_ready} !== 2'b10) $display("FAIL scan_state got busy=%b ready=%b exp 1 0", bus.busy, bus.in_ready);
    else n_pass++;
    start = n_results;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.syn_valid, bus.syn_zero, bus.syn_weight, bus.blk_idx} !== '0)
      $display("FAIL scan_reset_values got ready=%b busy=%b v=%b z=%b w=%0d blk=%0d exp all 0",
               bus.in_ready, bus.busy, bus.syn_valid, bus.syn_zero, bus.syn_weight, bus.blk_idx);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (Z + 64) @(negedge clk);
    n_checks++;
    if (n_results !== start) $display("FAIL scan_reset_no_result got %0d results exp 0", n_results - start);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_data();
    test_reset_in_scan();
    test_parity();
    test_restart();
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
